// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding, NOP constant and IF/ID record shared by the fetch stage
package fetch_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DROP} fetch_state_e;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register, priority flush > hold > load > bubble
module if_id_reg import fetch_pkg::*; (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   flush,
   input  logic   hold,
   input  logic   load,
   input  if_id_t d,
   output if_id_t q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
      else if (flush) q <= '{valid: 1'b0, pc: q.pc, instr: NOP_INSTR};
      else if (!hold) q <= load ? d : '{valid: 1'b0, pc: q.pc, instr: NOP_INSTR};
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, one-outstanding imem fetch FSM and IF/ID register.
// Defining FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_redirect_cnt.
module fetch_stage import fetch_pkg::*; #(
   parameter int              PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            pc_sel,
   input  logic [31:0]     branch_target,
   output logic            imem_req,
   output logic [PC_W-3:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            if_id_valid,
   output logic [PC_W-1:0] if_id_pc,
   output logic [31:0]     if_id_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_redirect_cnt
`endif
);
   fetch_state_e    state, state_n;
   logic [PC_W-1:0] pc, pc_n, pc_inc, tgt;
   logic [31:0]     hold_buf, hold_buf_n, ld_instr;
   logic            load;
   if_id_t          d, q;
   logic            unused_bits;
   assign pc_inc = pc + PC_W'(4);
   assign tgt    = {branch_target[PC_W-1:2], 2'b00};
   assign unused_bits = ^{branch_target[31:PC_W], branch_target[1:0], q.pc[31:PC_W]};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         hold_buf <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         hold_buf <= hold_buf_n;
      end
   // pc always names the instruction being fetched; the chained request targets pc+4
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      hold_buf_n = hold_buf;
      load       = 1'b0;
      ld_instr   = imem_rdata;
      imem_req   = 1'b0;
      imem_addr  = pc[PC_W-1:2];
      case (state)
         IDLE: begin
            state_n = ISSUE;
            if (pc_sel) pc_n = tgt;
         end
         ISSUE:
            if (pc_sel) pc_n = tgt;
            else begin
               imem_req = 1'b1;
               state_n  = WAIT;
            end
         WAIT:
            if (imem_rvalid) begin
               if (pc_sel) begin
                  pc_n    = tgt;
                  state_n = ISSUE;
               end else if (stall) begin
                  hold_buf_n = imem_rdata;
                  state_n    = HOLD;
               end else begin
                  load      = 1'b1;
                  pc_n      = pc_inc;
                  imem_req  = 1'b1;
                  imem_addr = pc_inc[PC_W-1:2];
               end
            end else if (pc_sel) begin
               pc_n    = tgt;
               state_n = DROP;
            end
         HOLD:
            if (pc_sel) begin
               pc_n    = tgt;
               state_n = ISSUE;
            end else if (!stall) begin
               load     = 1'b1;
               ld_instr = hold_buf;
               pc_n     = pc_inc;
               state_n  = ISSUE;
            end
         DROP: begin
            if (pc_sel) pc_n = tgt;
            if (imem_rvalid) state_n = ISSUE;
         end
         default: state_n = IDLE;
      endcase
   end
   assign d = '{valid: 1'b1, pc: 32'(pc), instr: ld_instr};
   if_id_reg u_if_id (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (pc_sel),
      .hold  (stall),
      .load  (load),
      .d     (d),
      .q     (q)
   );
   assign if_id_valid = q.valid;
   assign if_id_pc    = q.pc[PC_W-1:0];
   assign if_id_instr = q.instr;
`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perf_fetch_cnt    <= '0;
         perf_redirect_cnt <= '0;
      end else begin
         if (load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (pc_sel) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: fetch_stage against a program-order fetch model and a latency-driven memory
module tb_fetch_stage;
   localparam int PC_W = 9;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            stall = 1'b0, pc_sel = 1'b0, imem_rvalid = 1'b0;
   logic [31:0]     branch_target = '0, imem_rdata = '0;
   logic            imem_req, if_id_valid;
   logic [PC_W-3:0] imem_addr;
   logic [PC_W-1:0] if_id_pc;
   logic [31:0]     if_id_instr;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]     perf_fetch_cnt, perf_redirect_cnt;
`endif
   fetch_stage #(.PC_W(PC_W), .RESET_PC('0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .pc_sel        (pc_sel),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .if_id_valid   (if_id_valid),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt    (perf_fetch_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );
   always #5 clk = ~clk;
   int n_chk = 0, n_bad = 0;
   // memory: one tracked request, answered after a fixed or random latency
   bit              outst;
   int              cd, fixed_lat;
   logic [PC_W-3:0] out_addr;
   // program-order model: next pc to deliver, stale response pending, word parked by a stall
   logic [PC_W-1:0] m_pc, e_pc;
   bit              m_stale, m_buf, e_valid;
   logic [31:0]     e_instr;
   int              m_fcnt, m_rcnt;
   logic            last_req, last_rv;
   logic [PC_W-3:0] last_addr;
   function automatic logic [31:0] word(input logic [PC_W-3:0] a);
      return 32'h5EED_0000 + 32'(a) * 32'h0001_0003;
   endfunction
   task automatic apply_reset();
      rst_n = 1'b0; pc_sel = 1'b0; stall = 1'b0; imem_rvalid = 1'b0; branch_target = '0;
      #1;
      n_chk++;
      if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc !== '0 || if_id_instr !== NOP) begin
         n_bad++;
         $display("FAIL reset req=%b valid=%b pc=%h instr=%h (want 0 0 0 %h)", imem_req, if_id_valid, if_id_pc, if_id_instr, NOP);
      end
`ifdef FETCH_PERF_CNT_EN
      n_chk++;
      if (perf_fetch_cnt !== 0 || perf_redirect_cnt !== 0) begin
         n_bad++;
         $display("FAIL reset_perf fetch=%0d redirect=%0d (want 0 0)", perf_fetch_cnt, perf_redirect_cnt);
      end
`endif
      outst = 0; cd = 0; m_pc = '0; m_stale = 0; m_buf = 0;
      e_valid = 0; e_pc = '0; e_instr = NOP; m_fcnt = 0; m_rcnt = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   task automatic step(input logic ps, input logic st, input logic [31:0] tgt);
      logic            was_out;
      logic [PC_W-1:0] tgt_pc;
      pc_sel = ps; stall = st; branch_target = tgt;
      imem_rvalid = 1'b0; imem_rdata = $urandom;
      if (outst) begin
         if (cd == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(out_addr);
         end else cd--;
      end
      #1;
      last_req = imem_req; last_addr = imem_addr; last_rv = imem_rvalid;
      was_out = outst;
      tgt_pc = PC_W'(tgt & ~32'd3);
      if (ps) begin
         e_valid = 0; e_instr = NOP; m_buf = 0; m_pc = tgt_pc;
         m_stale = was_out && !imem_rvalid;
         m_rcnt++;
      end else if (imem_rvalid && m_stale) begin
         m_stale = 0;
         if (!st) begin e_valid = 0; e_instr = NOP; end
      end else if (imem_rvalid && st) m_buf = 1;
      else if (imem_rvalid || (m_buf && !st)) begin
         e_valid = 1; e_pc = m_pc; e_instr = word(m_pc[PC_W-1:2]);
         m_pc = m_pc + PC_W'(4); m_buf = 0; m_fcnt++;
      end else if (!st) begin
         e_valid = 0; e_instr = NOP;
      end
      if (imem_req) begin
         n_chk++;
         if (ps || (was_out && !imem_rvalid) || imem_addr !== m_pc[PC_W-1:2]) begin
            n_bad++;
            $display("FAIL req t=%0t addr=%h want=%h pc_sel=%b outstanding=%b", $time, imem_addr, m_pc[PC_W-1:2], ps, was_out && !imem_rvalid);
         end
      end
      if (imem_rvalid) outst = 0;
      if (imem_req) begin
         outst = 1;
         cd = (fixed_lat == 0 ? int'($urandom_range(1, 3)) : fixed_lat) - 1;
         out_addr = imem_addr;
      end
      @(posedge clk); #1;
      n_chk++;
      if (if_id_valid !== e_valid || if_id_instr !== e_instr || (e_valid && if_id_pc !== e_pc)) begin
         n_bad++;
         $display("FAIL ifid t=%0t valid=%b pc=%h instr=%h want valid=%b pc=%h instr=%h", $time, if_id_valid, if_id_pc, if_id_instr, e_valid, e_pc, e_instr);
      end
`ifdef FETCH_PERF_CNT_EN
      n_chk++;
      if (perf_fetch_cnt !== m_fcnt || perf_redirect_cnt !== m_rcnt) begin
         n_bad++;
         $display("FAIL perf fetch=%0d redirect=%0d want %0d %0d", perf_fetch_cnt, perf_redirect_cnt, m_fcnt, m_rcnt);
      end
`endif
   endtask
   task automatic test_reset();
      fixed_lat = 1;
      apply_reset();
      step(0, 0, 0);
      n_chk++;
      if (last_req !== 1'b0) begin n_bad++; $display("FAIL idle_req got=%b want=0", last_req); end
      step(0, 0, 0);
      n_chk++;
      if (last_req !== 1'b1 || last_addr !== '0) begin n_bad++; $display("FAIL first_fetch req=%b addr=%h want 1 0", last_req, last_addr); end
   endtask
   task automatic test_sequential();
      logic            rq[7];
      logic [PC_W-3:0] ad[7];
      logic            vl[7];
      logic [PC_W-1:0] pcs[7];
      logic [31:0]     ins[7];
      fixed_lat = 1;
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         step(0, 0, 0);
         rq[i] = last_req; ad[i] = last_addr; vl[i] = if_id_valid; pcs[i] = if_id_pc; ins[i] = if_id_instr;
      end
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (rq[k+1] !== 1'b1 || ad[k+1] !== (PC_W-2)'(k)) begin n_bad++; $display("FAIL seq_addr k=%0d req=%b addr=%h want %h", k, rq[k+1], ad[k+1], k); end
         n_chk++;
         if (vl[k+2] !== 1'b1 || pcs[k+2] !== PC_W'(4 * k) || ins[k+2] !== word((PC_W-2)'(k))) begin
            n_bad++;
            $display("FAIL seq_ifid k=%0d valid=%b pc=%h instr=%h want pc=%h", k, vl[k+2], pcs[k+2], ins[k+2], 4 * k);
         end
      end
   endtask
   task automatic test_stall();
      logic [PC_W-1:0] p0;
      p0 = if_id_pc;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0);
         n_chk++;
         if (if_id_valid !== 1'b1 || if_id_pc !== p0) begin n_bad++; $display("FAIL stall_hold i=%0d pc=%h want %h", i, if_id_pc, p0); end
      end
      step(0, 0, 0);
      n_chk++;
      if (if_id_valid !== 1'b1 || if_id_pc !== p0 + PC_W'(4)) begin n_bad++; $display("FAIL stall_release pc=%h want %h", if_id_pc, p0 + PC_W'(4)); end
      repeat (4) step(0, 0, 0);
   endtask
   task automatic test_redirect_wait();
      bit found = 0;
      fixed_lat = 3;
      apply_reset();
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 32'h40);
      for (int i = 0; i < 8 && !found; i++) begin
         step(0, 0, 0);
         if (last_rv) found = 1;
      end
      n_chk++;
      if (!found || last_req !== 1'b0) begin n_bad++; $display("FAIL stale_rv found=%b req=%b want 1 0", found, last_req); end
      n_chk++;
      if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL stale_bubble valid=%b want 0", if_id_valid); end
      step(0, 0, 0);
      n_chk++;
      if (last_req !== 1'b1 || last_addr !== (PC_W-2)'(8'h10)) begin n_bad++; $display("FAIL redirect_addr req=%b addr=%h want 1 10", last_req, last_addr); end
      repeat (6) step(0, 0, 0);
   endtask
   task automatic test_coincident();
      fixed_lat = 1;
      apply_reset();
      repeat (3) step(0, 0, 0);
      step(1, 1, 32'h80);
      n_chk++;
      if (last_rv !== 1'b1 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
         n_bad++;
         $display("FAIL coincide rv=%b valid=%b instr=%h want 1 0 %h", last_rv, if_id_valid, if_id_instr, NOP);
      end
      step(0, 0, 0);
      n_chk++;
      if (last_req !== 1'b1 || last_addr !== (PC_W-2)'(8'h20)) begin n_bad++; $display("FAIL coincide_addr req=%b addr=%h want 1 20", last_req, last_addr); end
   endtask
   task automatic test_wrap();
      logic [PC_W-3:0] ad[5];
      step(0, 0, 0);
      step(1, 0, 32'h1F0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0);
         ad[i] = last_addr;
      end
      n_chk++;
      if (ad[3] !== (PC_W-2)'(8'h7F) || ad[4] !== '0) begin n_bad++; $display("FAIL wrap addr=%h,%h want 7f,00", ad[3], ad[4]); end
      step(1, 0, 32'h1237);
      step(0, 0, 0);
      n_chk++;
      if (last_req !== 1'b1 || last_addr !== (PC_W-2)'(8'h0D)) begin n_bad++; $display("FAIL tgt_mask addr=%h want 0d", last_addr); end
      step(0, 0, 0);
      n_chk++;
      if (if_id_valid !== 1'b1 || if_id_pc !== PC_W'(12'h034)) begin n_bad++; $display("FAIL tgt_pc pc=%h want 034", if_id_pc); end
   endtask
   task automatic test_reset_mid();
      fixed_lat = 3;
      apply_reset();
      repeat (3) step(0, 0, 0);
      apply_reset();
      step(0, 0, 0);
      step(0, 0, 0);
      n_chk++;
      if (last_req !== 1'b1 || last_addr !== '0) begin n_bad++; $display("FAIL resume req=%b addr=%h want 1 0", last_req, last_addr); end
      repeat (8) step(0, 0, 0);
   endtask
   task automatic test_random();
      fixed_lat = 0;
      apply_reset();
      step(0, 0, 0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 25, $urandom);
      n_chk++;
      if (m_fcnt < 300) begin n_bad++; $display("FAIL progress loads=%0d want >=300", m_fcnt); end
   endtask
   initial begin
      @(posedge clk); #1;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_coincident();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
